// File: rtl/tt_um_counter_shivam.sv
// tt_um_counter_shivam: 16-bit Fibonacci LFSR with an optional up/down counter mode.
// Optional feature macro: COUNTER_MODE_EN. When it is defined, ui_in[2] selects
// counter mode and ui_in[3] selects the count direction. When it is undefined,
// every step is an LFSR step.
// The state register drives every output directly, so no input reaches an
// output without passing through the register.
module tt_um_counter_shivam (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [7:0]  ui_in,
    input  logic [7:0]  uio_in,
    input  logic [15:0] Uin,
    output logic [15:0] Uout,
    output logic [7:0]  uo_out,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe
);

    localparam logic [15:0] ResetVal = 16'h0001;

    logic [15:0] state_q, state_d;
    logic [15:0] lfsr_next;
    logic [15:0] step_next;
    logic        run, load;
    logic        feedback;

    assign run  = ui_in[0];
    assign load = ui_in[1];

`ifdef COUNTER_MODE_EN
    logic mode, dir;
    assign mode = ui_in[2];
    assign dir  = ui_in[3];
    // These bits have no function in the tile.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, uio_in, ui_in[7:4]};
`else
    // These bits have no function in the tile. Mode and direction are also
    // unused when the tile is built as an LFSR only.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, uio_in, ui_in[7:2]};
`endif

    // Taps for x^16+x^14+x^13+x^11+1. An all-zero state would lock up, so it is forced back to 1.
    always_comb begin
        feedback  = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
        lfsr_next = (state_q == 16'h0000) ? 16'h0001 : {state_q[14:0], feedback};
    end

    // Select the value for one step: an LFSR advance, or a count when counter mode is built in.
    always_comb begin
        step_next = lfsr_next;
`ifdef COUNTER_MODE_EN
        if (mode) begin
            step_next = dir ? (state_q - 16'd1) : (state_q + 16'd1);
        end
`endif
    end

    // Next-state priority: load beats run. Disabled or idle cycles hold the state.
    always_comb begin
        state_d = state_q;
        if (ena) begin
            if (load) begin
                state_d = Uin;
            end else if (run) begin
                state_d = step_next;
            end
        end
    end

    // State register with a synchronous reset. Reset wins over ena, load and run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ResetVal;
        end else begin
            state_q <= state_d;
        end
    end

    // The outputs are direct copies of the state. All bidirectional pins are always driven.
    always_comb begin
        Uout    = state_q;
        uo_out  = state_q[7:0];
        uio_out = state_q[15:8];
        uio_oe  = 8'hFF;
    end

endmodule

// File: tb/tb_tt_um_counter_shivam.sv
// Testbench for tt_um_counter_shivam. It runs a vector table, a full LFSR
// period walk, the counter wrap sequence when COUNTER_MODE_EN is defined, and
// random stimulus checked against a reference model.
module tb_tt_um_counter_shivam;

    logic        clk;
    logic        rst;
    logic        ena;
    logic [7:0]  ui_in;
    logic [7:0]  uio_in;
    logic [15:0] Uin;
    logic [15:0] Uout;
    logic [7:0]  uo_out;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;

    int checks = 0;
    int errors = 0;

    tt_um_counter_shivam dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .Uin    (Uin),
        .Uout   (Uout),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ena;
        logic [7:0]  ui;
        logic [15:0] uin;
        logic [15:0] exp;
    } vec_t;

    // Reference model. It works from the polynomial exponents and from modular arithmetic.
    function automatic logic [15:0] model_next(logic [15:0] s, logic r, logic en,
                                               logic [7:0] ui, logic [15:0] uin);
        int exps[4] = '{16, 14, 13, 11};
        logic fb;
        int   v;
        if (r) return 16'h0001;
        if (!en) return s;
        if (ui[1]) return uin;
        if (!ui[0]) return s;
`ifdef COUNTER_MODE_EN
        if (ui[2]) begin
            v = int'(s);
            v = ui[3] ? (v + 65535) % 65536 : (v + 1) % 65536;
            return v[15:0];
        end
`endif
        if (s == 16'h0000) return 16'h0001;
        fb = 1'b0;
        foreach (exps[i]) fb = fb ^ s[exps[i] - 1];
        return {s[14:0], fb};
    endfunction

    task automatic check(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(string name, logic [15:0] exp);
        check({name, " Uout"}, Uout, exp);
        check({name, " uo_out"}, {8'h00, uo_out}, {8'h00, exp[7:0]});
        check({name, " uio_out"}, {8'h00, uio_out}, {8'h00, exp[15:8]});
        check({name, " uio_oe"}, {8'h00, uio_oe}, 16'h00FF);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(logic r, logic en, logic [7:0] ui, logic [15:0] uin);
        rst   = r;
        ena   = en;
        ui_in = ui;
        Uin   = uin;
        tick();
    endtask

    vec_t        vecs[12];
    logic [15:0] model;
    int          first_return;

    initial begin
        rst    = 1'b1;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'hA5;
        Uin    = 16'h0000;

        // Each row lists rst, ena, ui_in, Uin and the expected Uout after the edge.
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h0001};
        vecs[1]  = '{1'b1, 1'b1, 8'h03, 16'hAAAA, 16'h0001};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 16'h0000, 16'h0001};
        vecs[3]  = '{1'b0, 1'b1, 8'h01, 16'h0000, 16'h0002};
        vecs[4]  = '{1'b0, 1'b1, 8'h03, 16'hBEEF, 16'hBEEF};
        vecs[5]  = '{1'b0, 1'b0, 8'h03, 16'h1234, 16'hBEEF};
        vecs[6]  = '{1'b0, 1'b0, 8'h01, 16'h1234, 16'hBEEF};
        vecs[7]  = '{1'b0, 1'b1, 8'hF0, 16'h1234, 16'hBEEF};
        vecs[8]  = '{1'b0, 1'b1, 8'h02, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 8'h01, 16'h0000, 16'h0001};
        vecs[10] = '{1'b0, 1'b1, 8'h03, 16'h8000, 16'h8000};
        vecs[11] = '{1'b0, 1'b1, 8'h01, 16'h0000, 16'h0001};

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].ena, vecs[i].ui, vecs[i].uin);
            check_all($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Reset arrives while the state is stepping and a load is requested on the same edge.
        apply(1'b0, 1'b1, 8'h03, 16'h1357);
        apply(1'b0, 1'b1, 8'h01, 16'h0000);
        apply(1'b1, 1'b1, 8'h03, 16'h5555);
        check_all("reset over load", 16'h0001);

        // Walk a full LFSR period from the reset state and record the first return to 1.
        apply(1'b1, 1'b0, 8'h00, 16'h0000);
        apply(1'b1, 1'b0, 8'h00, 16'h0000);
        check_all("reset value", 16'h0001);
        first_return = 0;
        for (int n = 1; n <= 65535; n++) begin
            apply(1'b0, 1'b1, 8'h01, 16'h0000);
            if (n == 1) check("lfsr step1", Uout, 16'h0002);
            if (n == 10) check("lfsr step10", Uout, 16'h0400);
            if (n == 11) check("lfsr step11", Uout, 16'h0801);
            if (first_return == 0 && Uout == 16'h0001) first_return = n;
        end
        check("lfsr period", first_return[15:0], 16'hFFFF);
        apply(1'b0, 1'b1, 8'h00, 16'h0000);
        check_all("hold after period", 16'h0001);

`ifdef COUNTER_MODE_EN
        apply(1'b0, 1'b1, 8'h03, 16'hFFFE);
        apply(1'b0, 1'b1, 8'h05, 16'h0000);
        check_all("count up", 16'hFFFF);
        apply(1'b0, 1'b1, 8'h05, 16'h0000);
        check_all("count up wrap", 16'h0000);
        apply(1'b0, 1'b1, 8'h0D, 16'h0000);
        check_all("count down wrap", 16'hFFFF);
        apply(1'b0, 1'b1, 8'h0D, 16'h0000);
        check_all("count down", 16'hFFFE);
`endif

        // Random stimulus compared against the reference model on every cycle.
        apply(1'b1, 1'b0, 8'h00, 16'h0000);
        model = 16'h0001;
        for (int n = 0; n < 3000; n++) begin
            logic        r, en;
            logic [7:0]  ui;
            logic [15:0] uin;
            r   = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 7) != 0);
            ui  = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ui[1] = 1'b0;
            case ($urandom_range(0, 3))
                0:       uin = 16'h0000;
                1:       uin = 16'hFFFE;
                default: uin = 16'($urandom);
            endcase
            uio_in = 8'($urandom);
            model = model_next(model, r, en, ui, uin);
            apply(r, en, ui, uin);
            check($sformatf("random%0d", n), Uout, model);
            if (n % 500 == 0) check_all($sformatf("random outs%0d", n), model);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
